// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: operation select and controller states.
package alu_pkg;

  localparam logic [1:0] OP_PASS_A = 2'b00;
  localparam logic [1:0] OP_ADD    = 2'b01;
  localparam logic [1:0] OP_XOR    = 2'b10;
  localparam logic [1:0] OP_XNOR   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice, purely combinational; carry-out is non-zero only for ADD.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       y,
  output logic       cout
);

  always_comb begin
    y    = a;
    cout = 1'b0;
    case (op)
      OP_PASS_A: y = a;
      OP_ADD: begin
        y    = a ^ b ^ cin;
        cout = (a & b) | ((a ^ b) & cin);
      end
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer: result valid WIDTH cycles after acceptance, held in DONE until out_ready.
// Accepts a new request only in IDLE, so one operation is in flight at a time.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_cout,
  output logic             out_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] y_sr_q, y_sr_d;
  logic [1:0]       op_q, op_d;

  logic slice_y;
  logic slice_cout;

  alu_bit_slice u_slice (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .op   (op_q),
    .y    (slice_y),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      y_sr_q  <= '0;
      op_q    <= OP_PASS_A;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      y_sr_q  <= y_sr_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    y_sr_d  = y_sr_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = in_a;
          b_sr_d  = in_b;
          op_d    = in_op;
          carry_d = (in_op == OP_ADD) ? in_cin : 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Result enters at the MSB so that after WIDTH shifts bit 0 lands at y_sr[0].
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        y_sr_d  = {slice_y, y_sr_q[WIDTH-1:1]};
        carry_d = (op_q == OP_ADD) ? slice_cout : 1'b0;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // y_sr and carry are untouched outside SHIFT/accept, so the last result persists in IDLE.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_y     = y_sr_q;
  assign out_cout  = carry_q;
  assign out_zero  = ~|y_sr_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl with a result scoreboard and a behavioural reference model.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_op;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic         out_cout;
  logic         out_zero;

  typedef struct packed {
    logic [W-1:0] y;
    logic         cout;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_cout  (out_cout),
    .out_zero  (out_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input logic cin);
    exp_t       e;
    logic [W:0] s;
    e.cout = 1'b0;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    case (op)
      2'b00:   e.y = a;
      2'b01:   begin e.y = s[W-1:0]; e.cout = s[W]; end
      2'b10:   e.y = a ^ b;
      default: e.y = ~(a ^ b);
    endcase
    e.zero = (e.y == '0);
    return e;
  endfunction

  // Presents a request (called just after a rising edge) and returns just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                      input logic cin, input exp_t e, input bit push, input bit keep_valid);
    bit accepted = 0;
    in_a = a; in_b = b; in_op = op; in_cin = cin; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        accepted = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("accept", 64'(accepted), 64'd1);
    if (push) sb.push_back(e);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Waits for out_valid, checks latency and result, optionally stalls, then drains.
  task automatic receive(input string tag, input int hold);
    int   k = 0;
    exp_t e;
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      if (out_valid) break;
      check({tag, "_busy_rdy"}, 64'(in_ready), 64'd0);
    end
    check({tag, "_lat"}, 64'(k), 64'(W));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
      return;
    end
    e = sb.pop_front();
    check({tag, "_y"}, 64'(out_y), 64'(e.y));
    check({tag, "_cout"}, 64'(out_cout), 64'(e.cout));
    check({tag, "_zero"}, 64'(out_zero), 64'(e.zero));
    check({tag, "_done_rdy"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      in_a = ~in_a;
      in_b = in_b + 8'h11;
      @(posedge clk); #1;
      check({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_y"}, 64'(out_y), 64'(e.y));
      check({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_drain_vld"}, 64'(out_valid), 64'd0);
    check({tag, "_keep_y"}, 64'(out_y), 64'(e.y));
    check({tag, "_keep_cout"}, 64'(out_cout), 64'(e.cout));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    logic         rcin;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'b00;
    in_cin = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_out_cout", 64'(out_cout), 64'd0);
    check("rst_out_zero", 64'(out_zero), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with full carry ripple and wrap to zero
    e.y = 8'h00; e.cout = 1'b1; e.zero = 1'b1;
    send(8'hFF, 8'h01, 2'b01, 1'b0, e, 1, 0);
    receive("add_ff", 0);

    e.y = 8'h80; e.cout = 1'b0; e.zero = 1'b0;
    send(8'h35, 8'h4A, 2'b01, 1'b1, e, 1, 0);
    receive("add_cin", 0);

    e.y = 8'hAA; e.cout = 1'b0; e.zero = 1'b0;
    send(8'hA5, 8'h0F, 2'b10, 1'b1, e, 1, 0);
    receive("xor", 0);

    e.y = 8'h00; e.cout = 1'b0; e.zero = 1'b1;
    send(8'hA5, 8'h5A, 2'b11, 1'b1, e, 1, 0);
    receive("xnor", 0);

    e.y = 8'h3C; e.cout = 1'b0; e.zero = 1'b0;
    send(8'h3C, 8'hC3, 2'b00, 1'b1, e, 1, 0);
    receive("pass", 0);

    // Backpressure: operands change while the result is held
    e.y = 8'h7E; e.cout = 1'b0; e.zero = 1'b0;
    send(8'h5D, 8'h21, 2'b01, 1'b0, e, 1, 0);
    receive("bp", 5);

    // Reset mid-SHIFT at count 3: nothing may come out of the aborted request
    e = model(8'h12, 8'h34, 2'b01, 1'b0);
    send(8'h12, 8'h34, 2'b01, 1'b0, e, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_vld", 64'(out_valid), 64'd0);
    check("mid_rst_rdy", 64'(in_ready), 64'd1);
    check("mid_rst_y", 64'(out_y), 64'd0);
    check("mid_rst_cout", 64'(out_cout), 64'd0);
    check("mid_rst_zero", 64'(out_zero), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      check("post_rst_vld", 64'(out_valid), 64'd0);
    end
    e.y = 8'h5B; e.cout = 1'b1; e.zero = 1'b0;
    send(8'hC8, 8'h93, 2'b01, 1'b0, e, 1, 0);
    receive("after_rst", 0);

    // Back-to-back with in_valid held: second accepted only after the drain
    e.y = 8'h0F; e.cout = 1'b0; e.zero = 1'b0;
    send(8'h0F, 8'hAA, 2'b00, 1'b0, e, 1, 1);
    in_a = 8'h81; in_b = 8'h81; in_op = 2'b01; in_cin = 1'b0;
    receive("b2b_1", 0);
    check("b2b_idle_rdy", 64'(in_ready), 64'd1);
    e.y = 8'h02; e.cout = 1'b1; e.zero = 1'b0;
    send(8'h81, 8'h81, 2'b01, 1'b0, e, 1, 0);
    receive("b2b_2", 0);

    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rop = 2'($urandom_range(0, 3)); rcin = 1'($urandom_range(0, 1));
      send(ra, rb, rop, rcin, model(ra, rb, rop, rcin), 1, 0);
      receive("rand", i % 2);
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_serial_ctrl.md
Name: alu_serial_ctrl

Overview:
- Bit-serial sequencer that drives a single 1-bit ALU slice over WIDTH cycles to produce a WIDTH-bit result.
- Operands are accepted on a valid/ready input handshake and presented LSB-first to the slice.
- The carry is registered between bits; the result is shifted in and held until the consumer accepts it.
- Sits between the operand source, such as the register-file read port, and the writeback stage; lets one small slice serve full-width operations.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  controller can accept a request (IDLE only).
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  2  operation select: 00 PASS_A, 01 ADD, 10 XOR, 11 XNOR.
- in_cin  input  1  carry-in; used by ADD only.
- out_valid  output  1  result valid (DONE only).
- out_ready  input  1  consumer accepts result.
- out_y  output  WIDTH  result.
- out_cout  output  1  final carry of ADD; 0 for other ops.
- out_zero  output  1  1 when out_y == 0.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset: state=IDLE, counter=0, carry=0, all shift regs=0; in_ready=1, out_valid=0, out_y=0, out_cout=0, out_zero=1.
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch a, b and op into shift regs; carry = in_cin if op==ADD, else 0; count=0; go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each cycle, the slice sees a_sr[0], b_sr[0], carry and op.
  - Slice result bit shifts into y_sr MSB (y_sr shifts right); a_sr and b_sr shift right.
  - carry <= slice carry for ADD; held 0 otherwise.
  - count++; when count==WIDTH-1, go to DONE.
- Slice function per bit:
  - PASS_A: y=a.
  - ADD: y=a^b^c, cout=ab|(a^b)c.
  - XOR: y=a^b.
  - XNOR: y=~(a^b).
- DONE:
  - out_valid=1; out_y=y_sr; out_cout=carry; out_zero = ~|y_sr.
  - Outputs are stable while out_ready=0.
  - On out_ready, go to IDLE; out_y, out_cout and out_zero keep their last values.
- Latency: handshake accepted at edge T; out_valid rises after edge T+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles: accept, WIDTH shifts, drain.
- in_valid during SHIFT/DONE is ignored; the requester must hold it until accepted.
- in_ready is never asserted in DONE, so no same-cycle drain-and-accept.
- Operands are sampled only at acceptance; later changes on in_a/in_b/in_op have no effect.
- ADD wrap-around: sum modulo 2^WIDTH; overflow is reported only via out_cout.
- Reset asserted mid-SHIFT or in DONE: immediate return to reset values; the partial result is discarded and no out_valid pulse occurs.
- out_ready while not in DONE is ignored.

Decomposition:
- Shared package alu_pkg contains:
  - op encodings OP_PASS_A=2'b00, OP_ADD=2'b01, OP_XOR=2'b10, OP_XNOR=2'b11;
  - state enum IDLE/SHIFT/DONE.
- One natural sub-module: alu_bit_slice, purely combinational.
  - Inputs: a, b, cin, op[1:0].
  - Outputs: y, cout.
- The controller owns all registers: state, counter of width ceil(log2(WIDTH)), shift regs and carry.

Test Plan:
- WIDTH=8, ADD a=0xFF b=0x01 cin=0 -> out_y=0x00, out_cout=1, out_zero=1; out_valid exactly 8 cycles after acceptance.
- ADD a=0x35 b=0x4A cin=1 -> out_y=0x80, out_cout=0, out_zero=0.
- XOR a=0xA5 b=0x0F -> 0xAA; XNOR a=0xA5 b=0x5A -> 0x00 with out_zero=1, out_cout=0; PASS_A a=0x3C -> 0x3C.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_y stable, in_ready=0; change in_a meanwhile -> result unaffected.
- rst_n pulsed low at SHIFT count=3 -> outputs immediately at reset values, no out_valid; a new request then completes correctly.
- Back-to-back requests with in_valid held high -> second accepted only after out_ready drain; the two results arrive in order and are correct.
